// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer: accepts one branch from decode, collects operands,
// drives the comparator for one cycle and issues flush + PC redirect when taken.
module branch_ctrl #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_op,
    input  logic [31:0]      br_pc4,
    input  logic [15:0]      br_off,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic [2:0]       cmp_op,
    output logic [31:0]      cmp_rs,
    output logic [31:0]      cmp_rt,
    input  logic             cmp_taken,
    output logic             stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             illegal_op,
    output logic             timeout,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE, REDIRECT} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_t      state, state_d;
    logic [2:0]  op_q;
    logic [31:0] pc4_q;
    logic [15:0] off_q;
    logic [31:0] rs_q, rt_q;
    logic        rs_have, rt_have;
    logic [7:0]  wait_cnt;
    logic        illegal_q, timeout_q;
    logic [CNT_W-1:0] branch_q, taken_q;

    logic accept, illegal_d, timeout_d, inc_branch, inc_taken;
    logic op_legal, rt_skip, rs_have_nxt, rt_have_nxt;

    assign op_legal    = br_op inside {3'b001, 3'b010, 3'b011, 3'b100};
    assign rt_skip     = (br_op == 3'b011) || (br_op == 3'b100);
    assign rs_have_nxt = rs_have | rs_ready;
    // rt_have is preset for single-operand ops, so this is true for them
    assign rt_have_nxt = rt_have | rt_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
        inc_branch = 1'b0;
        inc_taken  = 1'b0;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (br_valid) begin
                        accept = 1'b1;
                        if (!op_legal)
                            illegal_d = 1'b1;
                        else if (rs_ready && (rt_ready || rt_skip))
                            state_d = RESOLVE;
                        else
                            state_d = WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (rs_have_nxt && rt_have_nxt) begin
                        state_d = RESOLVE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                RESOLVE: begin
                    inc_branch = 1'b1;
                    if (cmp_taken) begin
                        inc_taken = 1'b1;
                        state_d   = REDIRECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REDIRECT: state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            pc4_q     <= '0;
            off_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_have   <= 1'b0;
            rt_have   <= 1'b0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            branch_q  <= '0;
            taken_q   <= '0;
        end else begin
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (inc_branch) branch_q <= branch_q + 1'b1;
            if (inc_taken)  taken_q  <= taken_q + 1'b1;
            if (accept) begin
                op_q     <= br_op;
                pc4_q    <= br_pc4;
                off_q    <= br_off;
                rs_have  <= rs_ready;
                rs_q     <= rs_ready ? rs_val : '0;
                rt_have  <= rt_ready || rt_skip;
                rt_q     <= (rt_ready && !rt_skip) ? rt_val : '0;
                wait_cnt <= '0;
            end else if (state == WAIT_OPS) begin
                if (!rs_have && rs_ready) begin
                    rs_have <= 1'b1;
                    rs_q    <= rs_val;
                end
                if (!rt_have && rt_ready) begin
                    rt_have <= 1'b1;
                    rt_q    <= rt_val;
                end
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign br_ready       = (state == IDLE);
    assign stall          = (state != IDLE);
    assign cmp_op         = (state == RESOLVE) ? op_q : '0;
    assign cmp_rs         = (state == RESOLVE) ? rs_q : '0;
    assign cmp_rt         = (state == RESOLVE) ? rt_q : '0;
    assign flush          = (state == REDIRECT);
    assign redirect_valid = (state == REDIRECT);
    assign redirect_pc    = (state == REDIRECT) ? pc4_q + {{14{off_q[15]}}, off_q, 2'b00} : '0;
    assign illegal_op     = illegal_q;
    assign timeout        = timeout_q;
    assign branch_count   = branch_q;
    assign taken_count    = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a transaction-level model predicts the event
// sequence of each branch; a monitor pops and compares as the DUT presents them.
module tb_branch_ctrl;

    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned CNT_W    = 16;
    localparam int K_RES = 0, K_REDIR = 1, K_ILL = 2, K_TO = 3, K_STALL = 4;

    logic clk, reset, kill, br_valid, br_ready;
    logic [2:0] br_op;
    logic [31:0] br_pc4;
    logic [15:0] br_off;
    logic rs_ready, rt_ready;
    logic [31:0] rs_val, rt_val;
    logic [2:0] cmp_op;
    logic [31:0] cmp_rs, cmp_rt;
    logic cmp_taken, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic illegal_op, timeout;
    logic [CNT_W-1:0] branch_count, taken_count;

    branch_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .kill(kill),
        .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
        .br_pc4(br_pc4), .br_off(br_off),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .rs_val(rs_val), .rt_val(rt_val),
        .cmp_op(cmp_op), .cmp_rs(cmp_rs), .cmp_rt(cmp_rt), .cmp_taken(cmp_taken),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .illegal_op(illegal_op), .timeout(timeout),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic branch_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return $signed(a) > 0;
            3'd4:    return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    // external comparator
    assign cmp_taken = branch_taken(cmp_op, cmp_rs, cmp_rt);

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } rec_t;

    rec_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned bc = 0;
    int unsigned tc = 0;
    bit          started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        rec_t r;
        r.kind = kind; r.a = a; r.b = b; r.c = c;
        sb.push_back(r);
    endtask

    task automatic pop_expect(input int kind, output rec_t r, output bit ok);
        n_vec++;
        ok = 1'b0;
        r.kind = -1; r.a = '0; r.b = '0; r.c = '0;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d expected no event", kind);
        end else begin
            r  = sb.pop_front();
            ok = (r.kind == kind);
            if (!ok) begin
                n_bad++;
                $display("FAIL event_order: got kind %0d expected kind %0d", kind, r.kind);
            end
        end
    endtask

    // Monitor: compares every observable event against the scoreboard
    initial begin
        rec_t r;
        bit   ok;
        int   run;
        run = 0;
        wait (started);
        forever begin
            @(negedge clk);
            check("ready_vs_stall", 32'(br_ready), 32'(!stall));
            if (stall) begin
                run++;
            end else if (run > 0) begin
                pop_expect(K_STALL, r, ok);
                if (ok) begin
                    check("stall_cycles", 32'(run), r.a);
                    check("branch_count", 32'(branch_count), r.b);
                    check("taken_count", 32'(taken_count), r.c);
                end
                run = 0;
            end
            if (cmp_op != 3'd0) begin
                pop_expect(K_RES, r, ok);
                if (ok) begin
                    check("cmp_op", 32'(cmp_op), r.a);
                    check("cmp_rs", cmp_rs, r.b);
                    check("cmp_rt", cmp_rt, r.c);
                end
            end else begin
                check("cmp_idle_zero", cmp_rs | cmp_rt, 32'd0);
            end
            if (flush || redirect_valid) begin
                pop_expect(K_REDIR, r, ok);
                if (ok) begin
                    check("flush", 32'(flush), 32'd1);
                    check("redirect_valid", 32'(redirect_valid), 32'd1);
                    check("redirect_pc", redirect_pc, r.a);
                end
            end
            if (illegal_op) pop_expect(K_ILL, r, ok);
            if (timeout)    pop_expect(K_TO, r, ok);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_ops(input int t, input logic need_rt, input logic [31:0] rs, input logic [31:0] rt,
                             input int d_rs, input int d_rt);
        rs_ready = (t == d_rs) || (t > d_rs && $urandom_range(0, 1) == 1);
        rs_val   = (t == d_rs) ? rs : $urandom;
        if (need_rt) begin
            rt_ready = (t == d_rt) || (t > d_rt && $urandom_range(0, 1) == 1);
            rt_val   = (t == d_rt) ? rt : $urandom;
        end else begin
            rt_ready = 1'($urandom_range(0, 1));
            rt_val   = $urandom;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            check("drain_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // One branch: model predicts the event sequence, then the cycles are driven.
    task automatic run_br(input logic [2:0] op, input logic [31:0] pc4, input logic [15:0] off,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input int d_rs, input int d_rt, input int kill_at);
        logic        legal, need_rt;
        logic [31:0] sx;
        int          d, rc, len;
        bit          to_pulse;
        legal    = (op >= 3'd1) && (op <= 3'd4);
        need_rt  = (op == 3'd1) || (op == 3'd2);
        sx       = {{16{off[15]}}, off};
        d        = (need_rt && d_rt > d_rs) ? d_rt : d_rs;
        rc       = d + 1;
        len      = 0;
        to_pulse = 1'b0;
        if (kill_at == 0) begin
            len = 0;
        end else if (!legal) begin
            push(K_ILL, '0, '0, '0);
        end else if (d > int'(MAX_WAIT)) begin
            if (kill_at >= 1 && kill_at <= int'(MAX_WAIT)) len = kill_at;
            else begin len = int'(MAX_WAIT); to_pulse = 1'b1; end
        end else if (kill_at >= 1 && kill_at < rc) begin
            len = kill_at;
        end else begin
            push(K_RES, 32'(op), rs, need_rt ? rt : 32'd0);
            if (kill_at == rc) begin
                len = rc;
            end else begin
                bc++;
                if (branch_taken(op, rs, rt)) begin
                    tc++;
                    push(K_REDIR, pc4 + (sx << 2), '0, '0);
                    len = rc + 1;
                end else begin
                    len = rc;
                end
            end
        end
        if (len > 0) push(K_STALL, 32'(len), 32'(bc), 32'(tc));
        if (to_pulse) push(K_TO, '0, '0, '0);

        for (int t = 0; t <= len + 1; t++) begin
            br_valid = (t == 0);
            br_op    = (t == 0) ? op  : 3'($urandom);
            br_pc4   = (t == 0) ? pc4 : $urandom;
            br_off   = (t == 0) ? off : 16'($urandom);
            kill     = (t == kill_at);
            drive_ops(t, need_rt, rs, rt, d_rs, d_rt);
            @(negedge clk);
            if (t == 0) check("br_ready_at_offer", 32'(br_ready), 32'd1);
            @(posedge clk); #1;
        end
        br_valid = 1'b0;
        kill     = 1'b0;
        drain();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return $urandom;
            2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(1, 9));
        endcase
    endfunction

    task automatic check_reset_outputs();
        check("rst_br_ready", 32'(br_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_cmp_op", 32'(cmp_op), 32'd0);
        check("rst_illegal_op", 32'(illegal_op), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_branch_count", 32'(branch_count), 32'd0);
        check("rst_taken_count", 32'(taken_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1; kill = 1'b0; br_valid = 1'b0; br_op = '0; br_pc4 = '0; br_off = '0;
        rs_ready = 1'b0; rt_ready = 1'b0; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        reset   = 1'b0;
        started = 1'b1;

        run_br(3'd1, 32'h0040_0004, 16'h0003, 32'd5, 32'd5, 0, 0, -1);      // beq taken
        run_br(3'd2, 32'h0040_0100, 16'h0010, 32'd7, 32'd7, 0, 0, -1);      // bne not taken
        run_br(3'd4, 32'h0000_0000, 16'hFFFF, 32'd0, 32'd0, 3, 0, -1);      // bgez, wrap
        run_br(3'd1, 32'h0000_1000, 16'h0004, 32'd1, 32'd1, 0, 1000, -1);   // timeout
        run_br(3'd1, 32'h0000_2000, 16'h0008, 32'd9, 32'd9, 0, 0, 1);       // kill in RESOLVE
        run_br(3'd7, 32'h0000_3000, 16'h0001, 32'd1, 32'd1, 0, 0, -1);      // illegal
        run_br(3'd1, 32'h0000_4000, 16'h0002, 32'd3, 32'd3, 0, 0, 0);       // kill blocks accept
        run_br(3'd3, 32'h0000_5000, 16'h0002, 32'd0, 32'd0, 0, 0, -1);      // bgtz on zero
        run_br(3'd1, 32'h0000_6000, 16'h0002, 32'd4, 32'd4, 0, 8, -1);      // rt at last chance

        // reset while waiting for an operand
        push(K_STALL, 32'd3, 32'd0, 32'd0);
        bc = 0; tc = 0;
        br_valid = 1'b1; br_op = 3'd1; br_pc4 = 32'h100; br_off = 16'h1;
        rs_ready = 1'b1; rs_val = 32'd1; rt_ready = 1'b0; kill = 1'b0;
        @(posedge clk); #1;
        br_valid = 1'b0; rs_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        drain();
        run_br(3'd1, 32'h0040_0004, 16'h0003, 32'd5, 32'd5, 0, 0, -1);

        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] rs, rt;
            int          d_rs, d_rt, k;
            int unsigned r;
            r    = $urandom_range(0, 15);
            op   = (r < 14) ? 3'(1 + r % 4) : 3'($urandom_range(0, 7));
            rs   = pick();
            rt   = ($urandom_range(0, 1) == 1) ? rs : pick();
            d_rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
            d_rt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
            k    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_br(op, $urandom, 16'($urandom), rs, rt, d_rs, d_rt, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
